// File: rtl/panic_cell_allocator_if.sv
// Allocator bus: the parser's single-cycle allocation request/grant and the
// consumer's cell-return strobe.
//   master : parser/consumer side (drives req, size and free_*)
//   slave  : allocator side (drives the grant, intense flag)
interface panic_cell_allocator_if #(
  parameter int CELL_ID_WIDTH = 16,
  parameter int LEN_WIDTH     = 16
);
  logic                     alloc_mem_req;
  logic [LEN_WIDTH-1:0]     alloc_mem_size;
  logic [CELL_ID_WIDTH-1:0] alloc_cell_id;
  logic                     alloc_port_id;
  logic                     alloc_mem_success;
  logic                     alloc_mem_intense;
  logic                     free_valid;
  logic [CELL_ID_WIDTH-1:0] free_cell_id;
  logic                     free_port_id;

  modport master (
    output alloc_mem_req, alloc_mem_size, free_valid, free_cell_id, free_port_id,
    input  alloc_cell_id, alloc_port_id, alloc_mem_success, alloc_mem_intense
  );

  modport slave (
    input  alloc_mem_req, alloc_mem_size, free_valid, free_cell_id, free_port_id,
    output alloc_cell_id, alloc_port_id, alloc_mem_success, alloc_mem_intense
  );
endinterface

// File: rtl/panic_cell_allocator.sv
// Packet-buffer cell allocator with two per-bank circular free lists.
// Ports:
//   clk            clock
//   rst            asynchronous reset, active-low
//   bus            allocation/free bus (slave side)
//   free_err       registered one-cycle pulse for an illegal/ignored free
//   free_cnt0/1    registered free-cell counts of bank 0 / bank 1
//   alloc_fail_cnt saturating count of failed allocation requests
module panic_cell_allocator #(
  parameter int CELL_ID_WIDTH  = 16,
  parameter int LEN_WIDTH      = 16,
  parameter int CELL_NUM       = 64,
  parameter int CELL_SIZE      = 2048,
  parameter int INTENSE_THRESH = 8,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  panic_cell_allocator_if.slave       bus,
  output logic                        free_err,
  output logic [$clog2(CELL_NUM):0]   free_cnt0,
  output logic [$clog2(CELL_NUM):0]   free_cnt1,
  output logic [CNT_WIDTH-1:0]        alloc_fail_cnt
);
  localparam int PTR_W = $clog2(CELL_NUM);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] CELL_SIZE_U = 32'(CELL_SIZE);
  localparam logic [31:0] THRESH_U    = 32'(INTENSE_THRESH);

  typedef enum logic {INIT, RUN} state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         init_idx_q, init_idx_d;
  logic [PTR_W-1:0]         head_q [2];
  logic [PTR_W-1:0]         head_d [2];
  logic [PTR_W-1:0]         tail_q [2];
  logic [PTR_W-1:0]         tail_d [2];
  logic [CNT_W-1:0]         cnt_q  [2];
  logic [CNT_W-1:0]         cnt_d  [2];
  logic [CELL_ID_WIDTH-1:0] mem_q  [2][CELL_NUM];
  logic                     free_err_q, free_err_d;
  logic [CNT_WIDTH-1:0]     fail_q, fail_d;

  logic                     sel;
  logic                     size_ok;
  logic                     success;
  logic                     id_ok;
  logic                     free_ok;
  logic [1:0]               push;
  logic [1:0]               pop;
  logic [CELL_ID_WIDTH-1:0] wr_data;
  logic [CNT_W:0]           total;

  // Grant path: combinational from registered counts and heads.
  always_comb begin
    // Larger bank wins, tie goes to bank 0; an empty bank can only win if
    // both are empty, which the count check below rejects.
    sel     = (cnt_q[1] > cnt_q[0]);
    size_ok = (bus.alloc_mem_size != '0) && (32'(bus.alloc_mem_size) <= CELL_SIZE_U);
    success = bus.alloc_mem_req && (state_q == RUN) && size_ok && (cnt_q[sel] != '0);
    id_ok   = ({1'b0, bus.free_cell_id} < (CELL_ID_WIDTH+1)'(CELL_NUM));
    free_ok = bus.free_valid && (state_q == RUN) && id_ok &&
              (cnt_q[bus.free_port_id] < CNT_W'(CELL_NUM));
    total   = {1'b0, cnt_q[0]} + {1'b0, cnt_q[1]};
  end

  assign bus.alloc_mem_success = success;
  assign bus.alloc_cell_id     = success ? mem_q[sel][head_q[sel]] : '0;
  assign bus.alloc_port_id     = success ? sel : 1'b0;
  assign bus.alloc_mem_intense = (state_q == INIT) || (32'(total) < THRESH_U);

  // Next-state: FSM, pointers, counters.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    wr_data    = bus.free_cell_id;
    free_err_d = bus.free_valid && !free_ok;
    fail_d     = fail_q;
    push       = '0;
    pop        = '0;

    case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        wr_data    = CELL_ID_WIDTH'(init_idx_q);
        if (init_idx_q == PTR_W'(CELL_NUM - 1)) state_d = RUN;
      end
      RUN: state_d = RUN;
      default: state_d = INIT;
    endcase

    if (bus.alloc_mem_req && !success && (fail_q != '1)) fail_d = fail_q + 1'b1;

    for (int b = 0; b < 2; b++) begin
      pop[b]    = success && (sel == 1'(b));
      push[b]   = (state_q == INIT) || (free_ok && (bus.free_port_id == 1'(b)));
      head_d[b] = head_q[b] + PTR_W'(pop[b]);
      tail_d[b] = tail_q[b] + PTR_W'(push[b]);
      cnt_d[b]  = cnt_q[b] + CNT_W'(push[b]) - CNT_W'(pop[b]);
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      free_err_q <= 1'b0;
      fail_q     <= '0;
      for (int b = 0; b < 2; b++) begin
        head_q[b] <= '0;
        tail_q[b] <= '0;
        cnt_q[b]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      free_err_q <= free_err_d;
      fail_q     <= fail_d;
      for (int b = 0; b < 2; b++) begin
        head_q[b] <= head_d[b];
        tail_q[b] <= tail_d[b];
        cnt_q[b]  <= cnt_d[b];
      end
    end
  end

  // Free-list storage: contents are only meaningful between head and tail,
  // and INIT rebuilds them, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (push[b]) mem_q[b][tail_q[b]] <= wr_data;
    end
  end

  assign free_err       = free_err_q;
  assign free_cnt0      = cnt_q[0];
  assign free_cnt1      = cnt_q[1];
  assign alloc_fail_cnt = fail_q;
endmodule

// File: tb/tb_panic_cell_allocator.sv
module tb_panic_cell_allocator;
  localparam int CELL_NUM = 64;

  typedef struct {
    int succ;
    int id;
    int port;
    int intense;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        free_err;
  logic [6:0]  free_cnt0;
  logic [6:0]  free_cnt1;
  logic [31:0] alloc_fail_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model
  int   q0[$];
  int   q1[$];
  exp_t sb[$];
  int   m_run  = 0;
  int   m_idx  = 0;
  int   m_fail = 0;
  int   m_err  = 0;

  panic_cell_allocator_if #(.CELL_ID_WIDTH(16), .LEN_WIDTH(16)) bus ();

  panic_cell_allocator #(
    .CELL_ID_WIDTH(16), .LEN_WIDTH(16), .CELL_NUM(CELL_NUM),
    .CELL_SIZE(2048), .INTENSE_THRESH(8), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .free_err(free_err), .free_cnt0(free_cnt0), .free_cnt1(free_cnt1),
    .alloc_fail_cnt(alloc_fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    sb.delete();
    m_run  = 0;
    m_idx  = 0;
    m_fail = 0;
    m_err  = 0;
  endtask

  // One clock cycle: drive inputs, push the expected grant, compare at the
  // falling edge, then advance the model across the rising edge.
  task automatic step(input logic req, input int size, input logic fv,
                      input int fid, input logic fp);
    exp_t e;
    exp_t got;
    int   c0, c1, sel, fok;
    c0 = q0.size();
    c1 = q1.size();
    bus.alloc_mem_req  = req;
    bus.alloc_mem_size = 16'(size);
    bus.free_valid     = fv;
    bus.free_cell_id   = 16'(fid);
    bus.free_port_id   = fp;
    sel = (c1 > c0) ? 1 : 0;
    e.succ    = (req && m_run && size > 0 && size <= 2048 && ((sel == 0) ? c0 : c1) > 0) ? 1 : 0;
    e.id      = e.succ ? ((sel == 0) ? q0[0] : q1[0]) : 0;
    e.port    = e.succ ? sel : 0;
    e.intense = (!m_run || (c0 + c1) < 8) ? 1 : 0;
    sb.push_back(e);
    fok = (fv && m_run && fid < CELL_NUM && ((fp == 1'b0) ? c0 : c1) < CELL_NUM) ? 1 : 0;

    @(negedge clk);
    got = sb.pop_front();
    check_val("success", longint'(bus.alloc_mem_success), got.succ);
    check_val("cell_id", longint'(bus.alloc_cell_id), got.id);
    check_val("port_id", longint'(bus.alloc_port_id), got.port);
    check_val("intense", longint'(bus.alloc_mem_intense), got.intense);

    @(posedge clk);
    if (!m_run) begin
      q0.push_back(m_idx);
      q1.push_back(m_idx);
      m_idx++;
      if (m_idx == CELL_NUM) m_run = 1;
    end else begin
      if (e.succ) begin
        if (sel == 0) void'(q0.pop_front());
        else          void'(q1.pop_front());
      end
      if (fok) begin
        if (fp == 1'b0) q0.push_back(fid);
        else            q1.push_back(fid);
      end
    end
    if (req && !e.succ) m_fail++;
    m_err = (fv && !fok) ? 1 : 0;
    #1;
    check_val("free_err", longint'(free_err), m_err);
    check_val("free_cnt0", longint'(free_cnt0), q0.size());
    check_val("free_cnt1", longint'(free_cnt1), q1.size());
    check_val("fail_cnt", longint'(alloc_fail_cnt), m_fail);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    bus.alloc_mem_req  = 1'b1;
    bus.alloc_mem_size = 16'd100;
    bus.free_valid     = 1'b0;
    bus.free_cell_id   = '0;
    bus.free_port_id   = 1'b0;
    model_reset();

    // Reset state with a live request
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_success", longint'(bus.alloc_mem_success), 0);
    check_val("rst_cell_id", longint'(bus.alloc_cell_id), 0);
    check_val("rst_intense", longint'(bus.alloc_mem_intense), 1);
    check_val("rst_cnt0", longint'(free_cnt0), 0);
    check_val("rst_fail", longint'(alloc_fail_cnt), 0);
    check_val("rst_err", longint'(free_err), 0);
    rst = 1'b1;

    // INIT: 64 cycles, one request and one free inside it
    for (int i = 0; i < CELL_NUM; i++)
      step(i == 10, 100, i == 20, 1, 1'b0);
    check_val("init_cnt0", longint'(free_cnt0), 64);
    check_val("init_cnt1", longint'(free_cnt1), 64);

    // Back-to-back grants alternate banks
    for (int i = 0; i < 4; i++) step(1'b1, 1500, 1'b0, 0, 1'b0);

    // Size boundaries
    step(1'b1, 0, 1'b0, 0, 1'b0);
    step(1'b1, 2049, 1'b0, 0, 1'b0);
    step(1'b1, 2048, 1'b0, 0, 1'b0);
    step(1'b1, 1, 1'b0, 0, 1'b0);

    // Drain everything, then request on an empty pool
    while (q0.size() + q1.size() > 0) step(1'b1, 100, 1'b0, 0, 1'b0);
    step(1'b1, 100, 1'b0, 0, 1'b0);
    // Free to an empty bank in the same cycle as a request: no bypass
    step(1'b1, 100, 1'b1, 5, 1'b1);
    step(1'b1, 100, 1'b0, 0, 1'b0);

    // Fill bank 0, then overflow and out-of-range frees
    for (int i = 0; i < CELL_NUM; i++) step(1'b0, 0, 1'b1, i, 1'b0);
    step(1'b0, 0, 1'b1, 3, 1'b0);
    idle(1);
    step(1'b0, 0, 1'b1, 64, 1'b0);
    step(1'b0, 0, 1'b1, 64, 1'b1);
    idle(1);

    // Bank 0 down to 10, then simultaneous pop and push on bank 0
    while (q0.size() > 10) step(1'b1, 64, 1'b0, 0, 1'b0);
    step(1'b1, 200, 1'b1, 7, 1'b0);
    check_val("popush_cnt0", longint'(free_cnt0), 10);
    while (q0.size() > 0) step(1'b1, 300, 1'b0, 0, 1'b0);
    step(1'b1, 300, 1'b0, 0, 1'b0);

    // Refill a little, then reset mid-stream
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 20 + i, 1'(i));
    bus.alloc_mem_req  = 1'b1;
    bus.alloc_mem_size = 16'd100;
    bus.free_valid     = 1'b0;
    #1;
    check_val("pre_rst_success", longint'(bus.alloc_mem_success), 1);
    #1;
    rst = 1'b0;
    #1;
    check_val("mid_rst_success", longint'(bus.alloc_mem_success), 0);
    check_val("mid_rst_cell_id", longint'(bus.alloc_cell_id), 0);
    check_val("mid_rst_intense", longint'(bus.alloc_mem_intense), 1);
    check_val("mid_rst_cnt0", longint'(free_cnt0), 0);
    check_val("mid_rst_cnt1", longint'(free_cnt1), 0);
    check_val("mid_rst_fail", longint'(alloc_fail_cnt), 0);
    model_reset();
    rst = 1'b1;

    // Rebuild through INIT and grant again
    for (int i = 0; i < CELL_NUM; i++) step(1'b0, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 512, 1'b0, 0, 1'b0);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
